// File: rtl/ttl_reg_pipe.sv
// ---------------------------------------------------------------------------
// ttl_reg_pipe
//
// Purpose
//   Clocked register pipeline of DEPTH stages, each WIDTH bits wide, with a
//   valid bit travelling alongside every stage. It models a chain of octal
//   D registers used to delay video/sound data by a fixed number of pixel
//   clocks. The block adds a clock enable, a synchronous flush, a selectable
//   tap output and a registered occupancy count.
//
// Parameters
//   WIDTH      data bits per stage (>= 1)
//   DEPTH      number of register stages (>= 1); latency in enabled clocks
//   RESET_VAL  value loaded into every data stage on RESET or FLUSH
//   TAP_W      width of TAP_SEL; the default is max(1, clog2(DEPTH)).
//              It may be widened so that out-of-range selects can be driven.
//
// Ports
//   Clk        in   1         rising-edge clock, sole clock
//   RESET      in   1         synchronous, active-high reset
//   CE         in   1         clock enable; stages advance only when 1
//   FLUSH      in   1         synchronous clear of all stages
//   D          in   WIDTH     data into stage 0
//   VALID_IN   in   1         qualifies D
//   TAP_SEL    in   TAP_W     stage index driven on Q_TAP / VALID_TAP
//   Q          out  WIDTH     last-stage data (registered)
//   VALID_OUT  out  1         last-stage valid (registered)
//   Q_TAP      out  WIDTH     data of stage TAP_SEL (combinational mux)
//   VALID_TAP  out  1         valid of stage TAP_SEL (combinational mux)
//   FILL_CNT   out  CNT_W     number of stages currently holding valid data
//
// Edge priority: RESET > FLUSH > CE > hold.
// ---------------------------------------------------------------------------
module ttl_reg_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int                CNT_W     = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID_IN,
    input  logic [TAP_W-1:0] TAP_SEL,
    output logic [WIDTH-1:0] Q,
    output logic             VALID_OUT,
    output logic [WIDTH-1:0] Q_TAP,
    output logic             VALID_TAP,
    output logic [CNT_W-1:0] FILL_CNT
);

    // Stage storage: index 0 is the input stage, DEPTH-1 drives Q.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;

    // RESET and FLUSH have an identical effect on the datapath; RESET only
    // wins on priority, which matters for nothing else in this block.
    logic clear;
    assign clear = RESET | FLUSH;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Hold by default (CE = 0).
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        vld_d  = vld_q;
        fill_d = fill_q;

        if (clear) begin
            // Discards in-flight data and whatever D/VALID_IN carry this edge.
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VAL;
            end
            vld_d  = '0;
            fill_d = '0;
        end else if (CE) begin
            // Data shifts regardless of VALID_IN; invalid slots still move.
            data_d[0] = D;
            vld_d[0]  = VALID_IN;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // One word in, one word out: the modular sum nets to the right
            // value even if fill_q + 1 momentarily exceeds the counter range.
            fill_d = fill_q + CNT_W'(VALID_IN) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Q         = data_q[DEPTH-1];
    assign VALID_OUT = vld_q[DEPTH-1];
    assign FILL_CNT  = fill_q;

    // Tap mux. Defaulting to the last stage covers every TAP_SEL >= DEPTH,
    // and with DEPTH = 1 the only candidate is that same stage.
    always_comb begin
        Q_TAP     = data_q[DEPTH-1];
        VALID_TAP = vld_q[DEPTH-1];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (TAP_SEL == TAP_W'(i)) begin
                Q_TAP     = data_q[i];
                VALID_TAP = vld_q[i];
            end
        end
    end

endmodule

// File: tb/tb_ttl_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_ttl_reg_pipe
//
// Directed bench for ttl_reg_pipe. Three builds share the control/data
// inputs:
//   u_dut : WIDTH=8, DEPTH=4, RESET_VAL=8'hA5  (main checks)
//   u_tap : WIDTH=8, DEPTH=4, TAP_W=3          (out-of-range tap select)
//   u_d1  : WIDTH=8, DEPTH=1                   (single plain register)
// ---------------------------------------------------------------------------
module tb_ttl_reg_pipe;

    logic       Clk = 1'b0;
    logic       RESET, CE, FLUSH, VALID_IN;
    logic [7:0] D;
    logic [1:0] tap_sel;
    logic [2:0] tap_sel3;

    logic [7:0] q, q_tap;
    logic       valid_out, valid_tap;
    logic [2:0] fill_cnt;

    logic [7:0] t_q, t_q_tap;
    logic       t_valid_out, t_valid_tap;
    logic [2:0] t_fill_cnt;

    logic [7:0] s_q, s_q_tap;
    logic       s_valid_out, s_valid_tap;
    logic       s_fill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    ttl_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut (
        .Clk(Clk), .RESET(RESET), .CE(CE), .FLUSH(FLUSH), .D(D),
        .VALID_IN(VALID_IN), .TAP_SEL(tap_sel), .Q(q), .VALID_OUT(valid_out),
        .Q_TAP(q_tap), .VALID_TAP(valid_tap), .FILL_CNT(fill_cnt)
    );

    ttl_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .TAP_W(3)) u_tap (
        .Clk(Clk), .RESET(RESET), .CE(CE), .FLUSH(FLUSH), .D(D),
        .VALID_IN(VALID_IN), .TAP_SEL(tap_sel3), .Q(t_q), .VALID_OUT(t_valid_out),
        .Q_TAP(t_q_tap), .VALID_TAP(t_valid_tap), .FILL_CNT(t_fill_cnt)
    );

    ttl_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
        .Clk(Clk), .RESET(RESET), .CE(CE), .FLUSH(FLUSH), .D(D),
        .VALID_IN(VALID_IN), .TAP_SEL(1'b0), .Q(s_q), .VALID_OUT(s_valid_out),
        .Q_TAP(s_q_tap), .VALID_TAP(s_valid_tap), .FILL_CNT(s_fill_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        logic       exp_v [4];
        logic [7:0] tap_vals [4];

        RESET = 1'b1; CE = 1'b0; FLUSH = 1'b0; VALID_IN = 1'b0;
        D = 8'h00; tap_sel = 2'd0; tap_sel3 = 3'd0;

        // 1: reset state
        step();
        chk("rst_q",      q,         8'hA5);
        chk("rst_q_tap",  q_tap,     8'hA5);
        chk("rst_vout",   valid_out, 0);
        chk("rst_vtap",   valid_tap, 0);
        chk("rst_fill",   fill_cnt,  0);
        chk("rst_d1_q",   s_q,       8'h00);
        RESET = 1'b0;

        // 2: fill with 01..05, latency DEPTH
        CE = 1'b1; VALID_IN = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            D = 8'(k);
            step();
            chk("fill_cnt", fill_cnt, (k < 4) ? k : 4);
            chk("fill_q",   q,        (k >= 4) ? (k - 3) : 8'hA5);
            chk("fill_vo",  valid_out, (k >= 4) ? 1 : 0);
            chk("d1_q",     s_q,       k);
            chk("d1_vo",    s_valid_out, 1);
        end

        // 3: hold with CE=0, then drain with VALID_IN=0
        CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            D = 8'h80 + 8'(i);
            step();
            chk("hold_q",    q,        8'h02);
            chk("hold_fill", fill_cnt, 4);
        end
        exp_q = '{8'h03, 8'h04, 8'h05, 8'h50};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        CE = 1'b1; VALID_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D = 8'h50 + 8'(i);
            step();
            chk("drain_fill", fill_cnt, 3 - i);
            chk("drain_q",    q,        exp_q[i]);
            chk("drain_vo",   valid_out, exp_v[i]);
        end

        // 4: flush beats CE with 3 valid in flight
        VALID_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = 8'h61 + 8'(i);
            step();
        end
        chk("pre_flush_fill", fill_cnt, 3);
        FLUSH = 1'b1; D = 8'hFF; tap_sel = 2'd0;
        step();
        chk("flush_fill", fill_cnt,  0);
        chk("flush_vo",   valid_out, 0);
        chk("flush_q",    q,         8'hA5);
        chk("flush_vtap", valid_tap, 0);
        chk("flush_qtap", q_tap,     8'hA5);
        FLUSH = 1'b0; VALID_IN = 1'b0; D = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_flush_q",  q, (i < 3) ? 8'hA5 : 8'h00);
            chk("post_flush_vo", valid_out, 0);
        end

        // 5: tap select, stage0..3 = 11,22,33,44
        tap_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        VALID_IN = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            D = tap_vals[i];
            step();
        end
        CE = 1'b0; VALID_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            chk("tap_q", q_tap,     tap_vals[i]);
            chk("tap_v", valid_tap, 1);
        end
        tap_sel3 = 3'd5; #1;
        chk("tap_oor5", t_q_tap, 8'h44);
        tap_sel3 = 3'd7; #1;
        chk("tap_oor7", t_q_tap, 8'h44);
        tap_sel3 = 3'd1; #1;
        chk("tap3_sel1", t_q_tap, 8'h22);

        // 6: reset mid-stream with 2 valid words in flight
        RESET = 1'b1;
        step();
        RESET = 1'b0; CE = 1'b1; VALID_IN = 1'b1;
        D = 8'hB1; step();
        D = 8'hB2; step();
        chk("mid_fill2", fill_cnt, 2);
        RESET = 1'b1; D = 8'hB3;
        step();
        chk("mid_rst_fill", fill_cnt,    0);
        chk("mid_rst_vo",   valid_out,   0);
        chk("mid_rst_d1_q", s_q,         8'h00);
        chk("mid_rst_d1_v", s_valid_out, 0);
        RESET = 1'b0; VALID_IN = 1'b0; D = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_after_q",    q, (i < 3) ? 8'hA5 : 8'h00);
            chk("mid_after_vo",   valid_out, 0);
            chk("mid_after_fill", fill_cnt,  0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
